// File: rtl/bus_arbiter_2m_if.sv
// Requester-side bus link between one master and the arbiter.
// The master modport drives requests; the slave modport is the arbiter's view.
interface bus_arbiter_2m_if;
  logic        breq;
  logic        bgnt;
  logic        bstart;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  tsize;
  logic [31:0] rdata;
  logic        bdone;
  logic        berror;

  modport master (
    output breq,
    output bstart,
    output addr,
    output wdata,
    output tsize,
    input  bgnt,
    input  rdata,
    input  bdone,
    input  berror
  );

  modport slave (
    input  breq,
    input  bstart,
    input  addr,
    input  wdata,
    input  tsize,
    output bgnt,
    output rdata,
    output bdone,
    output berror
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter in front of a single-ported slave, with region decode.
// Define BUS_ARB_TIMEOUT_EN to add a watchdog that force-completes a stalled slave access.
module bus_arbiter_2m #(
  parameter logic [3:0] SLAVE_REGION = 4'hF
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_arbiter_2m_if.slave m0,
  bus_arbiter_2m_if.slave m1,
  output logic [31:0]     s_addr,
  output logic [31:0]     s_wdata,
  output logic [1:0]      s_tsize,
  output logic            s_bstart,
  output logic            s_ss,
  input  logic [31:0]     s_rdata,
  input  logic            s_bdone,
  input  logic            s_berror
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_BUSY = 2'd2,
    ST_DERR = 2'd3
  } state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   gnt0;
  logic   gnt1;

  logic        has_owner;
  logic        own_breq;
  logic        oth_breq;
  logic        own_bstart;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [1:0]  own_tsize;
  logic        in_region;
  logic        timeout;
  logic        done;
  logic        err;
  logic [31:0] rsp_rdata;
  logic        arb_go;
  logic        arb_pick;
  logic        release_gnt;

  // Current owner's request signals
  assign has_owner  = (state != ST_IDLE);
  assign own_breq   = owner ? m1.breq   : m0.breq;
  assign oth_breq   = owner ? m0.breq   : m1.breq;
  assign own_bstart = owner ? m1.bstart : m0.bstart;
  assign own_addr   = owner ? m1.addr   : m0.addr;
  assign own_wdata  = owner ? m1.wdata  : m0.wdata;
  assign own_tsize  = owner ? m1.tsize  : m0.tsize;
  assign in_region  = (own_addr[31:28] == SLAVE_REGION);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // Count BUSY cycles; the cycle whose increment would reach TIMEOUT completes with error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != ST_BUSY) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout = (state == ST_BUSY) && !s_bdone && (cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Completion: slave response, watchdog expiry, or decode error
  assign done      = ((state == ST_BUSY) && (s_bdone || timeout)) || (state == ST_DERR);
  assign err       = (state == ST_DERR) || ((state == ST_BUSY) && (s_bdone ? s_berror : timeout));
  assign rsp_rdata = ((state == ST_BUSY) && s_bdone) ? s_rdata : 32'd0;

  // Grant decision for IDLE and for the completion edge
  always_comb begin
    arb_go   = 1'b0;
    arb_pick = 1'b0;
    if (state == ST_IDLE) begin
      arb_go   = m0.breq | m1.breq;
      arb_pick = (m0.breq & m1.breq) ? ~last : m1.breq;
    end else if (done) begin
      arb_go   = oth_breq | own_breq;
      arb_pick = oth_breq ? ~owner : owner;
    end
  end

  assign release_gnt = ((state == ST_OWN) && !own_bstart && !own_breq) || (done && !arb_go);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (arb_go) state <= ST_OWN;
        ST_OWN: begin
          if (own_bstart) begin
            state <= in_region ? ST_BUSY : ST_DERR;
          end else if (!own_breq) begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY, ST_DERR: if (done) state <= arb_go ? ST_OWN : ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (arb_go) begin
        owner <= arb_pick;
        last  <= arb_pick;
        gnt0  <= ~arb_pick;
        gnt1  <= arb_pick;
      end else if (release_gnt) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
      end
    end
  end

  // Slave side follows the owner; quiet when nobody owns the bus
  assign s_addr   = has_owner ? own_addr  : 32'd0;
  assign s_wdata  = has_owner ? own_wdata : 32'd0;
  assign s_tsize  = has_owner ? own_tsize : 2'd0;
  assign s_bstart = (state == ST_OWN) && own_bstart && in_region;
  assign s_ss     = ((state == ST_OWN) || ((state == ST_BUSY) && !timeout)) && in_region;

  // Responses reach only the owner
  assign m0.bgnt   = gnt0;
  assign m1.bgnt   = gnt1;
  assign m0.bdone  = done && !owner;
  assign m1.bdone  = done && owner;
  assign m0.berror = err && !owner;
  assign m1.berror = err && owner;
  assign m0.rdata  = owner ? 32'd0 : rsp_rdata;
  assign m1.rdata  = owner ? rsp_rdata : 32'd0;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed self-checking bench for bus_arbiter_2m (timeout case runs when BUS_ARB_TIMEOUT_EN is defined).
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [1:0]  s_tsize;
  logic        s_bstart;
  logic        s_ss;
  logic [31:0] s_rdata;
  logic        s_bdone;
  logic        s_berror;

  int tests = 0;
  int fails = 0;

  bus_arbiter_2m_if m0_if ();
  bus_arbiter_2m_if m1_if ();

`ifdef BUS_ARB_TIMEOUT_EN
  bus_arbiter_2m #(.SLAVE_REGION(4'hF), .TIMEOUT(8)) dut (
`else
  bus_arbiter_2m #(.SLAVE_REGION(4'hF)) dut (
`endif
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (m0_if),
    .m1       (m1_if),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_tsize  (s_tsize),
    .s_bstart (s_bstart),
    .s_ss     (s_ss),
    .s_rdata  (s_rdata),
    .s_bdone  (s_bdone),
    .s_berror (s_berror)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    s_rdata      = 32'd0;
    s_bdone      = 1'b0;
    s_berror     = 1'b0;
    m0_if.breq   = 1'b0;
    m0_if.bstart = 1'b0;
    m0_if.addr   = 32'd0;
    m0_if.wdata  = 32'd0;
    m0_if.tsize  = 2'd0;
    m1_if.breq   = 1'b0;
    m1_if.bstart = 1'b0;
    m1_if.addr   = 32'd0;
    m1_if.wdata  = 32'd0;
    m1_if.tsize  = 2'd0;

    // Reset state
    cyc();
    cyc();
    #2;
    check("rst_m0_bgnt", 32'(m0_if.bgnt), 32'd0);
    check("rst_m1_bgnt", 32'(m1_if.bgnt), 32'd0);
    check("rst_s_ss", 32'(s_ss), 32'd0);
    check("rst_s_bstart", 32'(s_bstart), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_m0_bdone", 32'(m0_if.bdone), 32'd0);

    // Single request from m0
    rst_n       = 1'b1;
    m0_if.breq  = 1'b1;
    m0_if.addr  = 32'hF000_0010;
    m0_if.wdata = 32'hCAFE_0001;
    m0_if.tsize = 2'd2;
    #2;
    check("single_gnt_not_yet", 32'(m0_if.bgnt), 32'd0);
    check("single_idle_s_addr", s_addr, 32'd0);
    cyc();
    check("single_m0_bgnt", 32'(m0_if.bgnt), 32'd1);
    check("single_m1_bgnt", 32'(m1_if.bgnt), 32'd0);
    m0_if.bstart = 1'b1;
    #2;
    check("single_s_bstart", 32'(s_bstart), 32'd1);
    check("single_s_ss", 32'(s_ss), 32'd1);
    check("single_s_addr", s_addr, 32'hF000_0010);
    check("single_s_wdata", s_wdata, 32'hCAFE_0001);
    check("single_s_tsize", 32'(s_tsize), 32'd2);
    cyc();
    m0_if.bstart = 1'b0;
    #2;
    check("single_busy_s_bstart", 32'(s_bstart), 32'd0);
    check("single_busy_bdone", 32'(m0_if.bdone), 32'd0);
    cyc();
    cyc();
    s_bdone    = 1'b1;
    s_rdata    = 32'h1234_5678;
    m0_if.breq = 1'b0;
    #2;
    check("single_m0_bdone", 32'(m0_if.bdone), 32'd1);
    check("single_m0_rdata", m0_if.rdata, 32'h1234_5678);
    check("single_m0_berror", 32'(m0_if.berror), 32'd0);
    check("single_m1_bdone", 32'(m1_if.bdone), 32'd0);
    check("single_m1_rdata", m1_if.rdata, 32'd0);
    cyc();
    s_bdone = 1'b0;
    s_rdata = 32'd0;
    #2;
    check("single_release_gnt", 32'(m0_if.bgnt), 32'd0);
    check("single_bdone_pulse", 32'(m0_if.bdone), 32'd0);

    // Reset while m1's transaction is in flight
    m1_if.breq = 1'b1;
    m1_if.addr = 32'hF000_0040;
    cyc();
    check("rstmid_m1_bgnt", 32'(m1_if.bgnt), 32'd1);
    m1_if.bstart = 1'b1;
    cyc();
    m1_if.bstart = 1'b0;
    m1_if.breq   = 1'b0;
    rst_n        = 1'b0;
    #2;
    check("rstmid_busy_s_ss", 32'(s_ss), 32'd1);
    cyc();
    rst_n = 1'b1;
    #2;
    check("rstmid_m1_bgnt_low", 32'(m1_if.bgnt), 32'd0);
    check("rstmid_s_ss", 32'(s_ss), 32'd0);
    check("rstmid_s_addr", s_addr, 32'd0);
    cyc();
    s_bdone = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    #2;
    check("late_bdone_m1", 32'(m1_if.bdone), 32'd0);
    check("late_rdata_m1", m1_if.rdata, 32'd0);
    check("late_bdone_m0", 32'(m0_if.bdone), 32'd0);
    cyc();
    s_bdone = 1'b0;
    s_rdata = 32'd0;

    // Contention right after reset: m0 first, then strict alternation
    m0_if.breq = 1'b1;
    m0_if.addr = 32'hF000_0100;
    m1_if.breq = 1'b1;
    m1_if.addr = 32'hF000_0200;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #2;
      check("rr_m0_bgnt", 32'(m0_if.bgnt), 32'((i % 2) == 0));
      check("rr_m1_bgnt", 32'(m1_if.bgnt), 32'((i % 2) == 1));
      if ((i % 2) == 0) m0_if.bstart = 1'b1;
      else              m1_if.bstart = 1'b1;
      #1;
      check("rr_s_bstart", 32'(s_bstart), 32'd1);
      cyc();
      m0_if.bstart = 1'b0;
      m1_if.bstart = 1'b0;
      s_bdone      = 1'b1;
      s_rdata      = 32'hA000_0000 + 32'(i);
      #2;
      check("rr_m0_bdone", 32'(m0_if.bdone), 32'((i % 2) == 0));
      check("rr_m1_bdone", 32'(m1_if.bdone), 32'((i % 2) == 1));
      check("rr_rdata", ((i % 2) == 0) ? m0_if.rdata : m1_if.rdata, 32'hA000_0000 + 32'(i));
      check("rr_other_rdata", ((i % 2) == 0) ? m1_if.rdata : m0_if.rdata, 32'd0);
      cyc();
      s_bdone = 1'b0;
      s_rdata = 32'd0;
    end

    // Abandon: m0 holds the grant, drops breq without a bstart
    #2;
    check("abandon_m0_bgnt", 32'(m0_if.bgnt), 32'd1);
    check("abandon_m1_bgnt", 32'(m1_if.bgnt), 32'd0);
    m0_if.breq = 1'b0;
    cyc();
    #2;
    check("abandon_m0_released", 32'(m0_if.bgnt), 32'd0);
    check("abandon_m1_wait", 32'(m1_if.bgnt), 32'd0);
    cyc();
    #2;
    check("abandon_m1_granted", 32'(m1_if.bgnt), 32'd1);

    // Decode error on m1
    m1_if.addr   = 32'h2000_0000;
    m1_if.bstart = 1'b1;
    #1;
    check("derr_s_bstart", 32'(s_bstart), 32'd0);
    check("derr_s_ss", 32'(s_ss), 32'd0);
    check("derr_no_early_bdone", 32'(m1_if.bdone), 32'd0);
    cyc();
    m1_if.bstart = 1'b0;
    m1_if.breq   = 1'b0;
    #2;
    check("derr_m1_bdone", 32'(m1_if.bdone), 32'd1);
    check("derr_m1_berror", 32'(m1_if.berror), 32'd1);
    check("derr_m1_rdata", m1_if.rdata, 32'd0);
    check("derr_s_ss_resp", 32'(s_ss), 32'd0);
    check("derr_m0_bdone", 32'(m0_if.bdone), 32'd0);
    cyc();
    #2;
    check("derr_bdone_pulse", 32'(m1_if.bdone), 32'd0);
    check("derr_m1_released", 32'(m1_if.bgnt), 32'd0);

`ifdef BUS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers
    m0_if.breq = 1'b1;
    m0_if.addr = 32'hF000_0300;
    cyc();
    #2;
    check("to_m0_bgnt", 32'(m0_if.bgnt), 32'd1);
    m0_if.bstart = 1'b1;
    for (int k = 1; k < 8; k++) begin
      cyc();
      m0_if.bstart = 1'b0;
      #2;
      check("to_wait_bdone", 32'(m0_if.bdone), 32'd0);
      check("to_wait_s_ss", 32'(s_ss), 32'd1);
    end
    cyc();
    m0_if.breq = 1'b0;
    #2;
    check("to_m0_bdone", 32'(m0_if.bdone), 32'd1);
    check("to_m0_berror", 32'(m0_if.berror), 32'd1);
    check("to_m0_rdata", m0_if.rdata, 32'd0);
    check("to_s_ss", 32'(s_ss), 32'd0);
    cyc();
    #2;
    check("to_released", 32'(m0_if.bgnt), 32'd0);
    check("to_bdone_pulse", 32'(m0_if.bdone), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
